// File: rtl/booth_mul_unit_if.sv
// Request/response bundle for booth_mul_unit: valid/ready request carrying operands and tag,
// valid/ready response carrying the selected result word and the same tag.
interface booth_mul_unit_if #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic             in_word;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_word, in_rs1, in_rs2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_word, in_rs1, in_rs2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/booth_mul_unit.sv
// Radix-4 Booth iterative multiplier (MUL/MULH/MULHSU/MULHU) with tag pass-through and flush.
// Define MUL_WORD_OP_EN to honour in_word (MULW, 17-step early termination) at XLEN=64.
module booth_mul_unit #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  booth_mul_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN/2 + 2);
  localparam int HW = XLEN + 3;
  localparam int LW = XLEN + 2;
  localparam logic [CW-1:0] FULL_LAST = CW'(XLEN/2);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg;
  logic [XLEN:0]     mcand_reg;
  logic [HW-1:0]     hi_reg;
  logic [LW-1:0]     lo_reg;
  logic              sb_reg;
  logic [1:0]        op_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic [XLEN-1:0]   result_reg;
  logic [TAG_W-1:0]  result_tag_reg;

  logic              in_ready, out_valid, accept, last_step, finish;
  logic [CW-1:0]     last_cnt;

`ifdef MUL_WORD_OP_EN
  localparam logic [CW-1:0] WORD_LAST = CW'(16);
  logic word_in, word_reg;
  assign word_in  = (XLEN == 64) && bus.in_word;
  assign last_cnt = word_reg ? WORD_LAST : FULL_LAST;
`else
  logic in_word_unused;
  assign in_word_unused = bus.in_word;
  assign last_cnt       = FULL_LAST;
`endif

  // Operand extension to XLEN+1 bits according to the signedness of the op.
  logic          rs1_sign, rs2_sign;
  logic [XLEN:0] rs1_ext, rs2_ext;
  always_comb begin
    rs1_sign = (bus.in_op != 2'b11);
    rs2_sign = ~bus.in_op[1];
    rs1_ext  = {rs1_sign & bus.in_rs1[XLEN-1], bus.in_rs1};
    rs2_ext  = {rs2_sign & bus.in_rs2[XLEN-1], bus.in_rs2};
`ifdef MUL_WORD_OP_EN
    if (word_in) begin
      rs1_ext = (XLEN+1)'($signed(bus.in_rs1[31:0]));
      rs2_ext = (XLEN+1)'($signed(bus.in_rs2[31:0]));
    end
`endif
  end

  // One Booth step: recode, add/subtract into hi, arithmetic shift of {hi, lo, sb} by 2.
  logic [HW-1:0] x_ext, pp, sum, hi_step;
  logic [LW-1:0] lo_step;
  logic          sb_step, pp_one, pp_two, pp_neg;
  always_comb begin
    x_ext  = {{2{mcand_reg[XLEN]}}, mcand_reg};
    pp_one = 1'b0;
    pp_two = 1'b0;
    pp_neg = lo_reg[1];
    case ({lo_reg[1:0], sb_reg})
      3'b001, 3'b010, 3'b101, 3'b110: pp_one = 1'b1;
      3'b011, 3'b100:                 pp_two = 1'b1;
      default:                        pp_neg = 1'b0;
    endcase
    pp      = pp_two ? {x_ext[HW-2:0], 1'b0} : (pp_one ? x_ext : '0);
    sum     = hi_reg + (pp ^ {HW{pp_neg}}) + HW'(pp_neg);
    hi_step = {{2{sum[HW-1]}}, sum[HW-1:2]};
    lo_step = {sum[1:0], lo_reg[LW-1:2]};
    sb_step = lo_reg[1];
  end

  // After the last step the low 2*XLEN product bits sit in {hi, lo}.
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   res_sel;
  always_comb begin
    product = {hi_step[XLEN-3:0], lo_step};
    res_sel = (op_reg == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
`ifdef MUL_WORD_OP_EN
    // 17 steps leave product[31:0] at lo[XLEN-1:XLEN-32].
    if (word_reg) res_sel = XLEN'($signed(lo_step[XLEN-1 -: 32]));
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    last_step  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        last_step = (cnt_reg == last_cnt);
        if (last_step) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            accept     = 1'b1;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Flush beats everything, including a same-cycle accept.
    if (flush) begin
      state_next = IDLE;
      accept     = 1'b0;
      last_step  = 1'b0;
    end
    finish = last_step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg        <= '0;
      mcand_reg      <= '0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      sb_reg         <= 1'b0;
      op_reg         <= 2'b00;
      tag_reg        <= '0;
      result_reg     <= '0;
      result_tag_reg <= '0;
`ifdef MUL_WORD_OP_EN
      word_reg       <= 1'b0;
`endif
    end else begin
      if (accept) begin
        mcand_reg <= rs1_ext;
        lo_reg    <= {rs2_ext[XLEN], rs2_ext};
        hi_reg    <= '0;
        sb_reg    <= 1'b0;
        op_reg    <= bus.in_op;
        tag_reg   <= bus.in_tag;
        cnt_reg   <= '0;
`ifdef MUL_WORD_OP_EN
        word_reg  <= word_in;
`endif
      end else if (state_reg == BUSY && !flush) begin
        hi_reg  <= hi_step;
        lo_reg  <= lo_step;
        sb_reg  <= sb_step;
        cnt_reg <= last_step ? '0 : cnt_reg + CW'(1);
      end else if (flush) begin
        cnt_reg <= '0;
      end
      if (finish) begin
        result_reg     <= res_sel;
        result_tag_reg <= tag_reg;
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_result = result_reg;
  assign bus.out_tag    = result_tag_reg;
endmodule

// File: tb/tb_booth_mul_unit.sv
// Scoreboard bench for booth_mul_unit at XLEN=64: directed vectors pushed on accept,
// monitor checks latency on out_valid rise and result/tag on each retirement.
module tb_booth_mul_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  booth_mul_unit_if #(.XLEN(64), .TAG_W(4)) bus ();

  booth_mul_unit #(.XLEN(64), .TAG_W(4)) dut (
    .clk   (clk),
    .rst   (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] res;
    logic [3:0]  tag;
    int          lat;
    longint      acc;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  logic   prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, result/tag on handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (!prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got tag 0x%0h result 0x%0h expected no output",
                   bus.out_tag, bus.out_result);
        end else begin
          check("latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
        end
      end
      if (bus.out_ready && exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", bus.out_result, e.res);
        check("tag", 64'(bus.out_tag), 64'(e.tag));
        $display("retire tag=%0h result=%h expected=%h", bus.out_tag, bus.out_result, e.res);
      end
    end
    prev_valid = rst_n && bus.out_valid;
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic word, input logic [63:0] a,
                      input logic [63:0] b, input logic [3:0] tag, input logic [63:0] res,
                      input int lat, input bit expect_out, output int waits);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_word  = word;
    bus.in_rs1   = a;
    bus.in_rs2   = b;
    bus.in_tag   = tag;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits <= 200) begin
      waits++;
      @(negedge clk);
    end
    if (waits > 200) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 (tag 0x%0h)", tag);
    end else if (expect_out) begin
      exp_q.push_back('{res: res, tag: tag, lat: lat, acc: cyc + 1});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  tag;
    logic [63:0] res;
    int          lat;
  } vec_t;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
`ifdef MUL_WORD_OP_EN
  localparam logic [63:0] MULW_RES = 64'hFFFF_FFFF_8000_0000;
  localparam int          MULW_LAT = 17;
`else
  localparam logic [63:0] MULW_RES = 64'h2468_ACF0_8000_0000;
  localparam int          MULW_LAT = 33;
`endif

  vec_t vecs[8] = '{
    '{2'b11, 1'b0, ALL1, ALL1,   4'h1, 64'hFFFF_FFFF_FFFF_FFFE, 33},
    '{2'b00, 1'b0, ALL1, ALL1,   4'h2, 64'h0000_0000_0000_0001, 33},
    '{2'b01, 1'b0, ALL1, ALL1,   4'h3, 64'h0,                   33},
    '{2'b10, 1'b0, ALL1, 64'd2,  4'h4, ALL1,                    33},
    '{2'b01, 1'b0, MSB,  ALL1,   4'h7, 64'h0,                   33},
    '{2'b01, 1'b0, MSB,  MSB,    4'h8, 64'h4000_0000_0000_0000, 33},
    '{2'b11, 1'b0, MSB,  64'd2,  4'h9, 64'h1,                   33},
    '{2'b00, 1'b1, 64'h1234_5678_4000_0000, 64'd2, 4'hA, MULW_RES, MULW_LAT}
  };

  initial begin
    int  w;
    bit  seen;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_word   = 1'b0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic vectors including sign/unsigned corners and MULW.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].res,
           vecs[i].lat, 1'b1, w);
      wait_idle();
    end

    // Backpressure: result held for 5 cycles, then back-to-back accept on retire.
    bus.out_ready = 1'b0;
    send(2'b00, 1'b0, 64'd3, 64'd5, 4'h5, 64'd15, 33, 1'b1, w);
    begin
      int n = 0;
      while (!bus.out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", bus.out_result, 64'd15);
      check("bp_tag", 64'(bus.out_tag), 64'h5);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(2'b00, 1'b0, 64'd4, 64'd4, 4'h6, 64'd16, 33, 1'b1, w);
    check("b2b_accept_waits", 64'(w), 64'd0);
    wait_idle();

    // Flush on cycle 10 of BUSY with a competing request.
    send(2'b00, 1'b0, 64'd100, 64'd100, 4'hB, 64'd10000, 33, 1'b0, w);
    repeat (9) @(posedge clk);
    #1;
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_tag    = 4'hC;
    @(negedge clk);
    check("flush_busy_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("flush_no_output", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    send(2'b00, 1'b0, 64'd3, 64'd7, 4'hD, 64'd21, 33, 1'b1, w);
    wait_idle();

    // Asynchronous reset mid-BUSY.
    send(2'b00, 1'b0, 64'd9, 64'd9, 4'hE, 64'd81, 33, 1'b1, w);
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_out_result", bus.out_result, 64'd0);
    check("arst_out_tag", 64'(bus.out_tag), 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(2'b00, 1'b0, 64'd6, 64'd7, 4'hF, 64'd42, 33, 1'b1, w);
    wait_idle();

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
